// File: rtl/impl_conv_pkg.sv
// -----------------------------------------------------------------------------
// impl_conv_pkg
// Definitions shared by the delta encoder and decoder sides:
//   - state_e : reference-tracking FSM states (IDLE = no reference yet, RUN)
//   - SAT_EN  : build-time selection between saturating and wrapping adds
//   - accAdd  : accumulator + sign-extended delta helper, width-generic up to
//               ADD_W bits
// Configuration macro: IMPL_DECONV_SAT_EN
//   defined   -> delta additions saturate to [0, 2^width-1]
//   undefined -> delta additions wrap modulo 2^width
// -----------------------------------------------------------------------------
package impl_conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest datapath the helper supports. Callers zero/sign-extend into it.
  localparam int unsigned ADD_W = 32;

`ifdef IMPL_DECONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // accVal is an unsigned value of 'width' bits, zero-extended to ADD_W.
  // deltaSext is a two's-complement delta already sign-extended to ADD_W.
  // Two guard bits keep the true sum exact so saturation can see both
  // positive overflow and negative underflow.
  function automatic logic [ADD_W-1:0] accAdd(
    input logic [ADD_W-1:0] accVal,
    input logic [ADD_W-1:0] deltaSext,
    input int unsigned      width,
    input bit               satEn
  );
    logic        [ADD_W+1:0] one;
    logic        [ADD_W+1:0] mask;
    logic signed [ADD_W+1:0] sum;
    logic        [ADD_W+1:0] res;
    one  = {{(ADD_W+1){1'b0}}, 1'b1};
    mask = (one << width) - one;
    sum  = $signed({2'b00, accVal}) + $signed({{2{deltaSext[ADD_W-1]}}, deltaSext});
    if (satEn) begin
      if (sum[ADD_W+1]) begin
        res = '0;
      end else if (sum > $signed(mask)) begin
        res = mask;
      end else begin
        res = sum;
      end
    end else begin
      res = sum & mask;
    end
    return res[ADD_W-1:0];
  endfunction

endpackage

// File: rtl/impl_deconv_acc.sv
// -----------------------------------------------------------------------------
// impl_deconv_acc
// Accumulator register plus its add/saturate datapath. The parent decides
// when to reload or add; this block only computes and holds the value.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears accumulator)
//   load_i       : replace accumulator with data_i (absolute/sync beat)
//   add_i        : add sign-extended data_i to accumulator (delta beat)
//   data_i       : absolute value or two's-complement delta
//   acc_o        : current accumulator
//   acc_next_o   : value the accumulator takes on the next clock edge
// Configuration macro (via impl_conv_pkg): IMPL_DECONV_SAT_EN
// -----------------------------------------------------------------------------
module impl_deconv_acc
  import impl_conv_pkg::*;
#(
  parameter int unsigned COUNT_OF_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     add_i,
  input  logic [COUNT_OF_BITS-1:0] data_i,
  output logic [COUNT_OF_BITS-1:0] acc_o,
  output logic [COUNT_OF_BITS-1:0] acc_next_o
);

  logic [COUNT_OF_BITS-1:0] acc_q;
  logic [COUNT_OF_BITS-1:0] acc_d;
  logic [ADD_W-1:0]         accWide;
  logic [ADD_W-1:0]         deltaWide;
  logic [ADD_W-1:0]         sumWide;
  logic                     unusedSumHi;

  assign accWide   = {{(ADD_W-COUNT_OF_BITS){1'b0}}, acc_q};
  assign deltaWide = {{(ADD_W-COUNT_OF_BITS){data_i[COUNT_OF_BITS-1]}}, data_i};
  assign sumWide   = accAdd(accWide, deltaWide, COUNT_OF_BITS, SAT_EN);

  // The helper already clamps or masks to COUNT_OF_BITS, so the upper
  // bits of its result are always zero.
  assign unusedSumHi = |sumWide[ADD_W-1:COUNT_OF_BITS];

  // Reload wins over add; with neither, the accumulator holds.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = data_i;
    end else if (add_i) begin
      acc_d = sumWide[COUNT_OF_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o      = acc_q;
  assign acc_next_o = acc_d;

endmodule

// File: rtl/impl_deconv.sv
// -----------------------------------------------------------------------------
// impl_deconv
// Delta decoder: rebuilds absolute values from a stream of sync (absolute)
// beats and two's-complement delta beats, with a single registered output
// stage and valid/ready handshakes on both sides.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : absolute value (in_sync=1) or delta (in_sync=0)
//   in_sync    : marks in_data as an absolute reload
//   in_valid   : upstream beat present
//   in_ready   : beat can be accepted this cycle
//   out        : reconstructed value
//   out_valid  : out holds an unconsumed result
//   out_ready  : downstream takes out this cycle
//   acc        : current accumulator (observation)
//   err        : sticky, set by a delta arriving before any sync beat
// Configuration macro: IMPL_DECONV_SAT_EN (saturating instead of wrapping adds)
// -----------------------------------------------------------------------------
module impl_deconv
  import impl_conv_pkg::*;
#(
  parameter int unsigned COUNT_OF_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNT_OF_BITS-1:0] in_data,
  input  logic                     in_sync,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [COUNT_OF_BITS-1:0] out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COUNT_OF_BITS-1:0] acc,
  output logic                     err
);

  state_e                   state_q;
  logic [COUNT_OF_BITS-1:0] out_q;
  logic [COUNT_OF_BITS-1:0] out_d;
  logic                     out_valid_q;
  logic                     err_q;
  logic                     accept;
  logic                     consume;
  logic                     loadAcc;
  logic                     addAcc;

  // Single output register: room exists when it is empty or being drained.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  // Deltas seen in IDLE have no reference and are dropped.
  assign loadAcc = accept && in_sync;
  assign addAcc  = accept && !in_sync && (state_q == RUN);

  impl_deconv_acc #(
    .COUNT_OF_BITS(COUNT_OF_BITS)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (loadAcc),
    .add_i     (addAcc),
    .data_i    (in_data),
    .acc_o     (acc),
    .acc_next_o(out_d)
  );

  // The output register always mirrors the freshly updated accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_sync) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
            state_q     <= RUN;
          end else begin
            err_q <= 1'b1;
            if (consume) begin
              out_valid_q <= 1'b0;
            end
          end
        end
        RUN: begin
          out_q       <= out_d;
          out_valid_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: doc/impl_deconv.md
IMPL_DECONV -- requirements
Module: impl_deconv

Interface
REQ-001 Parameter COUNT_OF_BITS, default 4: width of every data port and of the accumulator.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_data  input  COUNT_OF_BITS  absolute value on sync beats; two's-complement delta otherwise.
REQ-005 in_sync  input  1  qualifies in_data as absolute (reload) rather than delta.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 out  output  COUNT_OF_BITS  reconstructed value.
REQ-009 out_valid  output  1  out holds an unconsumed result.
REQ-010 out_ready  input  1  downstream accepts out this cycle.
REQ-011 acc  output  COUNT_OF_BITS  current accumulator, for debug/observation.
REQ-012 err  output  1  sticky flag: delta beat received before any sync beat.

Function
REQ-013 Beat accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-014 in_ready SHALL be combinational: !out_valid || out_ready (single output register, full throughput).
REQ-015 FSM states: IDLE (no reference value) and RUN; reset enters IDLE.
REQ-016 IDLE + accepted sync beat: acc <= in_data, out <= in_data, out_valid <= 1, go RUN.
REQ-017 IDLE + accepted delta beat: beat dropped, acc unchanged, no output, err <= 1, stay IDLE.
REQ-018 RUN + accepted delta beat: acc <= acc + sign-extended in_data (modulo 2^COUNT_OF_BITS), out <= new acc, out_valid <= 1.
REQ-019 RUN + accepted sync beat: reload as REQ-016, stay RUN.
REQ-020 Latency SHALL be exactly one cycle from accepted beat to out_valid.
REQ-021 Simultaneous accept and consume: out_valid stays 1, out takes new result, no bubble.
REQ-022 Consume without accept: out_valid <= 0; out and acc hold.
REQ-023 out_valid && !out_ready: out, acc, out_valid held stable; in_ready = 0; upstream beat not accepted.
REQ-024 err SHALL remain set until reset; it never blocks processing.

Reset
REQ-025 Reset values: acc = 0, out = 0, out_valid = 0, err = 0, state = IDLE.
REQ-026 Reset asserted mid-stream overrides every other event in that cycle; a beat presented then is discarded; pending output is lost.
REQ-027 in_ready SHALL be 0 while rst = 1.

Configuration
REQ-028 Macro IMPL_DECONV_SAT_EN defined: delta addition saturates as unsigned to [0, 2^COUNT_OF_BITS-1] (positive overflow -> all ones, negative underflow -> 0).
REQ-029 Macro undefined: delta addition wraps modulo 2^COUNT_OF_BITS; no other behaviour differs.

Structure
REQ-030 Shared package impl_conv_pkg SHALL hold the FSM state enum (IDLE, RUN) and the saturating/wrapping add helper, shared with the encoder side.
REQ-031 One sub-module impl_deconv_acc: accumulator register plus add/saturate datapath; FSM and handshake stay in impl_deconv.

Verification (COUNT_OF_BITS = 4, out_ready = 1 unless stated)
REQ-032 Sync 1, delta +2, delta +1 on consecutive cycles -> out 1, 3, 4 on consecutive cycles, out_valid high three cycles, err = 0.
REQ-033 Delta +3 before any sync -> no out_valid, err = 1 and stays 1; following sync 5 -> out 5.
REQ-034 Sync 15, delta +1 -> out 0 (wrap) / 15 with IMPL_DECONV_SAT_EN; sync 1, delta 4'b1110 (-2) -> out 15 / 0 with SAT.
REQ-035 Sync 2, delta +1 with out_ready = 0 for 3 cycles -> out holds 2, in_ready = 0, acc = 2; on release out 3 next cycle, no beat lost.
REQ-036 Sync 7, delta +1, then rst = 1 for one cycle alongside delta +1 -> out_valid = 0, acc = 0, state IDLE; next delta sets err.
